// File: rtl/wrr_burst_arbiter.sv
// Weighted round-robin arbiter: per-requester burst credits, hold watchdog,
// and a mandatory idle cycle between consecutive grants.
module wrr_burst_arbiter #(
    parameter int unsigned NREQ     = 4,
    parameter int unsigned IDW      = 2,
    parameter int unsigned WW       = 4,
    parameter int unsigned MAX_HOLD = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic               beat,
    input  logic [NREQ*WW-1:0] weights,
    output logic [NREQ-1:0]    gnt,
    output logic               gnt_vld,
    output logic [IDW-1:0]     gnt_id,
    output logic               timeout,
    output logic [IDW-1:0]     timeout_id
);

    localparam int unsigned    HW       = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0]  HOLD_LIM = HW'(MAX_HOLD);
    localparam logic [IDW-1:0] LAST_ID  = IDW'(NREQ - 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state, state_n;
    logic [IDW-1:0]  ptr, ptr_n, id_n, tid_n, sel, cand;
    logic [WW-1:0]   credit, credit_n, wsel;
    logic [HW-1:0]   hold_cnt, hold_n;
    logic [NREQ-1:0] gnt_n;
    logic            tmo_n, found;
    logic            rel_a, rel_b, rel_c, rel;
    int unsigned     idx;

    // Rotating priority scan starting at ptr, wrapping at NREQ.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        idx   = 0;
        cand  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= NREQ)
                idx = idx - NREQ;
            cand = IDW'(idx);
            if (!found && req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    assign wsel  = weights[32'(sel)*WW +: WW];
    assign rel_a = !req[gnt_id];
    assign rel_b = beat && (credit == WW'(1));
    assign rel_c = (hold_cnt == HOLD_LIM);
    assign rel   = rel_a || rel_b || rel_c;

    always_comb begin
        state_n  = state;
        ptr_n    = ptr;
        id_n     = gnt_id;
        tid_n    = timeout_id;
        credit_n = credit;
        hold_n   = hold_cnt;
        gnt_n    = gnt;
        tmo_n    = 1'b0;
        case (state)
            IDLE: begin
                gnt_n = '0;
                if (found) begin
                    state_n    = GRANT;
                    gnt_n[sel] = 1'b1;
                    id_n       = sel;
                    credit_n   = (wsel == '0) ? WW'(1) : wsel;
                    hold_n     = HW'(1);
                end
            end
            GRANT: begin
                if (rel) begin
                    state_n = IDLE;
                    gnt_n   = '0;
                    ptr_n   = (gnt_id == LAST_ID) ? '0 : gnt_id + IDW'(1);
                    // Only a pure watchdog release is reported as a timeout.
                    if (rel_c && !rel_a && !rel_b) begin
                        tmo_n = 1'b1;
                        tid_n = gnt_id;
                    end
                end else begin
                    if (beat)
                        credit_n = credit - WW'(1);
                    if (hold_cnt != HOLD_LIM)
                        hold_n = hold_cnt + HW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            ptr        <= '0;
            credit     <= '0;
            hold_cnt   <= '0;
            gnt        <= '0;
            gnt_id     <= '0;
            timeout    <= 1'b0;
            timeout_id <= '0;
        end else begin
            state      <= state_n;
            ptr        <= ptr_n;
            credit     <= credit_n;
            hold_cnt   <= hold_n;
            gnt        <= gnt_n;
            gnt_id     <= id_n;
            timeout    <= tmo_n;
            timeout_id <= tid_n;
        end
    end

    assign gnt_vld = |gnt;

endmodule

// File: tb/tb_wrr_burst_arbiter.sv
// Self-checking bench for wrr_burst_arbiter (NREQ=4, WW=4, MAX_HOLD=8):
// vector table plus hand sequences for watchdog, weights and reset corners.
module tb_wrr_burst_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  req = '0;
    logic        beat = 1'b0;
    logic [15:0] weights = '0;
    logic [3:0]  gnt;
    logic        gnt_vld;
    logic [1:0]  gnt_id;
    logic        timeout;
    logic [1:0]  timeout_id;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic        beat;
        logic [15:0] w;
        logic [3:0]  gnt;
        logic [1:0]  id;
        logic        tmo;
        logic [1:0]  tid;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];

    wrr_burst_arbiter #(
        .NREQ(4), .IDW(2), .WW(4), .MAX_HOLD(8)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .beat(beat), .weights(weights),
        .gnt(gnt), .gnt_vld(gnt_vld), .gnt_id(gnt_id),
        .timeout(timeout), .timeout_id(timeout_id)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL sim_timeout: got no finish expected finish");
        $fatal(1);
    end

    function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic b,
                                input logic [15:0] w, input logic [3:0] g,
                                input logic [1:0] id, input logic t, input logic [1:0] tid);
        vec_t v;
        v.rst = r; v.req = rq; v.beat = b; v.w = w;
        v.gnt = g; v.id = id; v.tmo = t; v.tid = tid;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Drive one cycle of inputs, queue its expectation, compare after the edge.
    task automatic step(input vec_t v, input string tag);
        vec_t e;
        exp_q.push_back(v);
        rst = v.rst; req = v.req; beat = v.beat; weights = v.w;
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check({tag, ".gnt"},     32'(gnt),     32'(e.gnt));
        check({tag, ".gnt_vld"}, 32'(gnt_vld), 32'(|e.gnt));
        check({tag, ".gnt_id"},  32'(gnt_id),  32'(e.id));
        check({tag, ".timeout"}, 32'(timeout), 32'(e.tmo));
        if (e.tmo)
            check({tag, ".timeout_id"}, 32'(timeout_id), 32'(e.tid));
    endtask

    localparam logic [15:0] W2 = 16'h2222;
    localparam logic [15:0] W3 = 16'h2223;
    localparam logic [15:0] WH = 16'h3333;

    initial begin
        // reset, idle, first grant, withdrawal
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 4'b0000, 0, W2, 4'b0000, 0, 0, 0));
        for (int i = 0; i < 2; i++) tbl.push_back(mk(1, 4'b0000, 0, W2, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(1, 4'b0001, 0, W2, 4'b0001, 0, 0, 0));
        tbl.push_back(mk(1, 4'b0000, 0, W2, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(1, 4'b0000, 0, W2, 4'b0000, 0, 0, 0));
        // weighted rotation, all weights 2 (ptr starts at 1)
        tbl.push_back(mk(1, 4'b0011, 1, W2, 4'b0010, 1, 0, 0));
        tbl.push_back(mk(1, 4'b0011, 1, W2, 4'b0010, 1, 0, 0));
        tbl.push_back(mk(1, 4'b0011, 1, W2, 4'b0000, 1, 0, 0));
        tbl.push_back(mk(1, 4'b0011, 1, W2, 4'b0001, 0, 0, 0));
        tbl.push_back(mk(1, 4'b0011, 1, W2, 4'b0001, 0, 0, 0));
        tbl.push_back(mk(1, 4'b0011, 1, W2, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(1, 4'b0011, 1, W2, 4'b0010, 1, 0, 0));
        tbl.push_back(mk(1, 4'b0011, 1, W2, 4'b0010, 1, 0, 0));
        tbl.push_back(mk(1, 4'b0011, 1, W2, 4'b0000, 1, 0, 0));
        // weight[0]=3
        tbl.push_back(mk(1, 4'b0011, 1, W3, 4'b0001, 0, 0, 0));
        tbl.push_back(mk(1, 4'b0011, 1, W3, 4'b0001, 0, 0, 0));
        tbl.push_back(mk(1, 4'b0011, 1, W3, 4'b0001, 0, 0, 0));
        tbl.push_back(mk(1, 4'b0011, 1, W3, 4'b0000, 0, 0, 0));
        tbl.push_back(mk(1, 4'b0011, 1, W3, 4'b0010, 1, 0, 0));
        tbl.push_back(mk(1, 4'b0011, 1, W3, 4'b0010, 1, 0, 0));
        tbl.push_back(mk(1, 4'b0011, 1, W3, 4'b0000, 1, 0, 0));
        tbl.push_back(mk(1, 4'b0000, 0, W3, 4'b0000, 1, 0, 0));
        // withdrawal and pointer wrap 3->0
        tbl.push_back(mk(1, 4'b1000, 0, W3, 4'b1000, 3, 0, 0));
        tbl.push_back(mk(1, 4'b1001, 0, W3, 4'b1000, 3, 0, 0));
        tbl.push_back(mk(1, 4'b0001, 0, W3, 4'b0000, 3, 0, 0));
        tbl.push_back(mk(1, 4'b0001, 0, W3, 4'b0001, 0, 0, 0));
        tbl.push_back(mk(1, 4'b0000, 0, W3, 4'b0000, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i], $sformatf("tbl[%0d]", i));

        // watchdog: 8 cycles high, then forced release with timeout
        for (int i = 0; i < 8; i++)
            step(mk(1, 4'b0001, 0, WH, 4'b0001, 0, 0, 0), $sformatf("wd_hold[%0d]", i));
        step(mk(1, 4'b0001, 0, WH, 4'b0000, 0, 1, 0), "wd_release");
        step(mk(1, 4'b0001, 0, WH, 4'b0001, 0, 0, 0), "wd_regrant");
        // credit reaches 1 exactly at hold 8: beat release, no timeout
        for (int i = 1; i <= 7; i++)
            step(mk(1, 4'b0001, (i >= 6), WH, 4'b0001, 0, 0, 0), $sformatf("wdb_hold[%0d]", i));
        step(mk(1, 4'b0001, 1, WH, 4'b0000, 0, 0, 0), "wdb_release");
        step(mk(1, 4'b0000, 0, WH, 4'b0000, 0, 0, 0), "wdb_idle");

        // zero weight gives a 1-beat grant; new weight applies to the next grant only
        step(mk(1, 4'b0100, 1, 16'h3033, 4'b0100, 2, 0, 0), "zw_grant");
        step(mk(1, 4'b0100, 1, 16'h3533, 4'b0000, 2, 0, 0), "zw_release");
        step(mk(1, 4'b0100, 1, 16'h3533, 4'b0100, 2, 0, 0), "w5_grant");
        for (int i = 0; i < 4; i++)
            step(mk(1, 4'b0100, 1, 16'h3533, 4'b0100, 2, 0, 0), $sformatf("w5_hold[%0d]", i));
        step(mk(1, 4'b0100, 1, 16'h3533, 4'b0000, 2, 0, 0), "w5_release");

        // reset during cycle 3 of a grant to requester 2; ptr returns to 0
        step(mk(1, 4'b0100, 0, 16'h3533, 4'b0100, 2, 0, 0), "rm_grant");
        step(mk(1, 4'b0100, 0, 16'h3533, 4'b0100, 2, 0, 0), "rm_cyc2");
        step(mk(0, 4'b0100, 0, 16'h3533, 4'b0000, 0, 0, 0), "rm_reset");
        step(mk(1, 4'b1100, 0, 16'h3533, 4'b0100, 2, 0, 0), "rm_regrant");
        step(mk(1, 4'b0000, 0, 16'h3533, 4'b0000, 2, 0, 0), "rm_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
